// File: rtl/piso_pkg.sv
// Shared types and elaboration helpers for the piso_stream shifter.
// PISO_PARITY_EN adds the trailing parity beat state.
package piso_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift
`ifdef PISO_PARITY_EN
    , StParity
`endif
  } piso_state_e;

  function automatic int unsigned beats(input int unsigned width, input int unsigned lanes);
    return width / lanes;
  endfunction

  // Counter width: ceil(log2(n)), never below one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r = 1;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

  function automatic bit lanes_divide(input int unsigned width, input int unsigned lanes);
    return (lanes != 0) && ((width % lanes) == 0);
  endfunction

endpackage

// File: rtl/piso_stream_if.sv
// Load/serial bundle for piso_stream; the slave side is the shifter.
interface piso_stream_if #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned LANES = 1
);
  logic             en;
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] data_i;
  logic [LANES-1:0] data_o;
  logic             data_valid;
  logic             last;
  logic             busy;

  modport master (
    output en, load_valid, data_i,
    input  load_ready, data_o, data_valid, last, busy
  );

  modport slave (
    input  en, load_valid, data_i,
    output load_ready, data_o, data_valid, last, busy
  );
endinterface

// File: rtl/piso_hold_reg.sv
// Single-entry holding register with a full flag; push and pop are never
// asserted together by the owner.
module piso_hold_reg #(
  parameter int unsigned WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] data,
  output logic             full
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
      full <= 1'b0;
    end else if (push) begin
      data <= din;
      full <= 1'b1;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/piso_stream.sv
// Double-buffered parallel-in/serial-out shifter, LANES bits per beat.
// Optional trailing parity beat under PISO_PARITY_EN.
module piso_stream
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = 128,
  parameter int unsigned LANES     = 1,
  parameter bit          MSB_FIRST = 1'b1
) (
  input logic          clk,
  input logic          rst,
  piso_stream_if.slave bus
);

  localparam int unsigned     N       = beats(WIDTH, LANES);
  localparam int unsigned     CntW    = clog2_min1(N);
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  if (!lanes_divide(WIDTH, LANES)) begin : g_width_check
    $error("piso_stream: WIDTH must be a multiple of LANES");
  end

  piso_state_e      state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d, shift_adv, hold_data;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             hold_full, push, xfer, cnt_last;
  logic [LANES-1:0] beat;

  assign push      = bus.load_valid && !hold_full;
  assign cnt_last  = (cnt_q == LastCnt);
  assign beat      = MSB_FIRST ? shift_q[WIDTH-1 -: LANES] : shift_q[LANES-1:0];
  // Zero fill leaves the register empty once a word has fully drained.
  assign shift_adv = MSB_FIRST ? (shift_q << LANES) : (shift_q >> LANES);

  piso_hold_reg #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (xfer),
    .din  (bus.data_i),
    .data (hold_data),
    .full (hold_full)
  );

`ifdef PISO_PARITY_EN
  logic [LANES-1:0] par_q, par_d;
`endif

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    xfer    = 1'b0;
`ifdef PISO_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (hold_full) begin
          xfer    = 1'b1;
          state_d = StShift;
        end
      end
      StShift: begin
        if (bus.en) begin
          shift_d = shift_adv;
`ifdef PISO_PARITY_EN
          par_d   = par_q ^ beat;
`endif
          if (cnt_last) begin
            cnt_d = '0;
`ifdef PISO_PARITY_EN
            state_d = StParity;
`else
            if (hold_full) xfer = 1'b1;
            else           state_d = StIdle;
`endif
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
`ifdef PISO_PARITY_EN
      StParity: begin
        if (bus.en) begin
          if (hold_full) begin
            xfer    = 1'b1;
            state_d = StShift;
          end else begin
            state_d = StIdle;
          end
        end
      end
`endif
      default: state_d = StIdle;
    endcase
    // Back-to-back transfer overrides the shift so the next word starts at beat 0.
    if (xfer) begin
      shift_d = hold_data;
      cnt_d   = '0;
`ifdef PISO_PARITY_EN
      par_d   = '0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
`ifdef PISO_PARITY_EN
      par_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
`ifdef PISO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign bus.load_ready = !hold_full;
  assign bus.data_valid = (state_q != StIdle);
  assign bus.busy       = (state_q != StIdle) || hold_full;
`ifdef PISO_PARITY_EN
  assign bus.data_o     = (state_q == StParity) ? par_q : beat;
  assign bus.last       = (state_q == StParity);
`else
  assign bus.data_o     = beat;
  assign bus.last       = (state_q == StShift) && cnt_last;
`endif

endmodule

// File: tb/tb_piso_stream.sv
// Scoreboard bench for piso_stream over four parameter sets; tracks
// PISO_PARITY_EN in its expected beat model.
module tb_piso_stream;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  piso_stream_if #(.WIDTH(8),   .LANES(1)) i8   ();
  piso_stream_if #(.WIDTH(16),  .LANES(4)) i16m ();
  piso_stream_if #(.WIDTH(16),  .LANES(4)) i16l ();
  piso_stream_if #(.WIDTH(128), .LANES(1)) i128 ();

  piso_stream #(.WIDTH(8), .LANES(1), .MSB_FIRST(1'b1)) u_d8 (
    .clk (clk), .rst (rst), .bus (i8.slave));
  piso_stream #(.WIDTH(16), .LANES(4), .MSB_FIRST(1'b1)) u_d16m (
    .clk (clk), .rst (rst), .bus (i16m.slave));
  piso_stream #(.WIDTH(16), .LANES(4), .MSB_FIRST(1'b0)) u_d16l (
    .clk (clk), .rst (rst), .bus (i16l.slave));
  piso_stream #(.WIDTH(128), .LANES(1), .MSB_FIRST(1'b1)) u_d128 (
    .clk (clk), .rst (rst), .bus (i128.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected beats: {last, data[3:0]}.
  logic [4:0] q0[$];
  logic [4:0] q1[$];
  logic [4:0] q2[$];
  logic [4:0] q3[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] exp_beat(input logic [127:0] w, input int wd, input int ln,
                                          input bit msb, input int b);
    logic [3:0] r = '0;
    for (int j = 0; j < ln; j++) r[j] = msb ? w[wd - ln - b * ln + j] : w[b * ln + j];
    return r;
  endfunction

  task automatic put(input int id, input logic [4:0] e);
    case (id)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      2:       q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endtask

  task automatic push_exp(input int id, input logic [127:0] w, input int wd, input int ln,
                          input bit msb);
    int n = wd / ln;
    logic [3:0] b;
`ifdef PISO_PARITY_EN
    logic [3:0] p = '0;
    for (int i = 0; i < n; i++) begin
      b = exp_beat(w, wd, ln, msb, i);
      p ^= b;
      put(id, {1'b0, b});
    end
    put(id, {1'b1, p});
`else
    for (int i = 0; i < n; i++) begin
      b = exp_beat(w, wd, ln, msb, i);
      put(id, {i == n - 1, b});
    end
`endif
  endtask

  function automatic int qsz(input int id);
    case (id)
      0:       return q0.size();
      1:       return q1.size();
      2:       return q2.size();
      default: return q3.size();
    endcase
  endfunction

  function automatic logic dvld(input int id);
    case (id)
      0:       return i8.data_valid;
      1:       return i16m.data_valid;
      2:       return i16l.data_valid;
      default: return i128.data_valid;
    endcase
  endfunction

  task automatic drain(input int id, input string tag);
    for (int c = 0; c < 400 && !(qsz(id) == 0 && !dvld(id)); c++) tick();
    check(tag, {qsz(id) == 0, dvld(id)}, 2'b10);
  endtask

  // Beat monitors: a beat completes on an edge where data_valid and en are high.
  logic [4:0] e0, e1, e2, e3;
  always @(negedge clk) if (!rst && i8.data_valid && i8.en) begin
    check("d8 queue", q0.size() != 0, 1'b1);
    if (q0.size() != 0) begin
      e0 = q0.pop_front();
      check("d8 data", i8.data_o, e0[0]);
      check("d8 last", i8.last, e0[4]);
    end
  end
  always @(negedge clk) if (!rst && i16m.data_valid && i16m.en) begin
    check("d16m queue", q1.size() != 0, 1'b1);
    if (q1.size() != 0) begin
      e1 = q1.pop_front();
      check("d16m data", i16m.data_o, e1[3:0]);
      check("d16m last", i16m.last, e1[4]);
    end
  end
  always @(negedge clk) if (!rst && i16l.data_valid && i16l.en) begin
    check("d16l queue", q2.size() != 0, 1'b1);
    if (q2.size() != 0) begin
      e2 = q2.pop_front();
      check("d16l data", i16l.data_o, e2[3:0]);
      check("d16l last", i16l.last, e2[4]);
    end
  end
  always @(negedge clk) if (!rst && i128.data_valid && i128.en) begin
    check("d128 queue", q3.size() != 0, 1'b1);
    if (q3.size() != 0) begin
      e3 = q3.pop_front();
      check("d128 data", i128.data_o, e3[0]);
      check("d128 last", i128.last, e3[4]);
    end
  end

`ifdef PISO_PARITY_EN
  localparam int Extra = 1;
`else
  localparam int Extra = 0;
`endif

  int n;
  logic [127:0] wa, wb;

  initial begin
    rst = 1'b1;
    i8.en = 1'b1;   i8.load_valid = 1'b0;   i8.data_i = '0;
    i16m.en = 1'b1; i16m.load_valid = 1'b0; i16m.data_i = '0;
    i16l.en = 1'b1; i16l.load_valid = 1'b0; i16l.data_i = '0;
    i128.en = 1'b1; i128.load_valid = 1'b0; i128.data_i = '0;
    tick();
    tick();
    check("rst data_o", i8.data_o, 1'b0);
    check("rst data_valid", i8.data_valid, 1'b0);
    check("rst last", i8.last, 1'b0);
    check("rst busy", i8.busy, 1'b0);
    check("rst load_ready", i8.load_ready, 1'b1);
    check("rst d128 load_ready", i128.load_ready, 1'b1);
    rst = 1'b0;
    tick();

    // 8'hA5, one lane, MSB first; first beat one edge after accept.
    i8.load_valid = 1'b1; i8.data_i = 8'hA5;
    push_exp(0, 128'hA5, 8, 1, 1'b1);
    tick();
    i8.load_valid = 1'b0;
    check("a5 accept busy", i8.busy, 1'b1);
    check("a5 accept load_ready", i8.load_ready, 1'b0);
    check("a5 accept data_valid", i8.data_valid, 1'b0);
    tick();
    check("a5 latency data_valid", i8.data_valid, 1'b1);
    check("a5 hold empty", i8.load_ready, 1'b1);
    drain(0, "a5 drain");
    check("a5 idle busy", i8.busy, 1'b0);

    // 16'h1234, four lanes, both bit orders.
    i16m.load_valid = 1'b1; i16m.data_i = 16'h1234;
    i16l.load_valid = 1'b1; i16l.data_i = 16'h1234;
    push_exp(1, 128'h1234, 16, 4, 1'b1);
    push_exp(2, 128'h1234, 16, 4, 1'b0);
    tick();
    i16m.load_valid = 1'b0; i16l.load_valid = 1'b0;
    drain(1, "1234 msb drain");
    drain(2, "1234 lsb drain");

    // Two 128-bit words back to back, second loaded mid-word.
    wa = 128'habcdef0123456789abcdef0123456789;
    wb = 128'h9876543210fedcba9876543210fedcba;
    i128.load_valid = 1'b1; i128.data_i = wa;
    push_exp(3, wa, 128, 1, 1'b1);
    tick();
    i128.data_i = wb;
    check("w128 ready while held", i128.load_ready, 1'b0);
    tick();
    check("w128 first beat", i128.data_valid, 1'b1);
    check("w128 ready after xfer", i128.load_ready, 1'b1);
    push_exp(3, wb, 128, 1, 1'b1);
    tick();
    i128.load_valid = 1'b0;
    check("w128 second held", i128.load_ready, 1'b0);
    n = 1;
    for (int c = 0; c < 400 && i128.data_valid; c++) begin
      n++;
      tick();
    end
    check("w128 contiguous beats", n, 256 + 2 * Extra);
    drain(3, "w128 drain");

    // 8'hA5 with en low for three cycles after beat 3.
    i8.load_valid = 1'b1; i8.data_i = 8'hA5;
    push_exp(0, 128'hA5, 8, 1, 1'b1);
    tick();
    i8.load_valid = 1'b0;
    tick();
    n = 0;
    for (int c = 0; c < 100 && i8.data_valid; c++) begin
      i8.en = !(n >= 3 && n < 6);
      tick();
      if (!i8.en) begin
        check("stall data_o", i8.data_o, exp_beat(128'hA5, 8, 1, 1'b1, 3));
        check("stall last", i8.last, 1'b0);
        check("stall data_valid", i8.data_valid, 1'b1);
      end
      n++;
    end
    i8.en = 1'b1;
    check("stall total cycles", n, 11 + Extra);
    drain(0, "stall drain");

    // Reset at beat 4 of 8'hA5 with 8'hFF held.
    i8.load_valid = 1'b1; i8.data_i = 8'hA5;
    push_exp(0, 128'hA5, 8, 1, 1'b1);
    tick();
    i8.data_i = 8'hFF;
    tick();
    tick();
    i8.load_valid = 1'b0;
    tick();
    tick();
    check("pre-rst held", {i8.busy, i8.load_ready, i8.data_valid}, 3'b101);
    #2;
    rst = 1'b1;
    q0.delete();
    #1;
    check("async rst data_o", i8.data_o, 1'b0);
    check("async rst data_valid", i8.data_valid, 1'b0);
    check("async rst last", i8.last, 1'b0);
    check("async rst busy", i8.busy, 1'b0);
    check("async rst load_ready", i8.load_ready, 1'b1);
    tick();
    rst = 1'b0;
    tick();
    tick();
    check("post-rst quiet", {i8.data_valid, i8.busy}, 2'b00);
    i8.load_valid = 1'b1; i8.data_i = 8'h3C;
    push_exp(0, 128'h3C, 8, 1, 1'b1);
    tick();
    i8.load_valid = 1'b0;
    drain(0, "3c drain");

    // 8'h07: odd popcount, exercises the parity beat when enabled.
    i8.load_valid = 1'b1; i8.data_i = 8'h07;
    push_exp(0, 128'h07, 8, 1, 1'b1);
    tick();
    i8.load_valid = 1'b0;
    drain(0, "07 drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
